// File: rtl/dpram_fwft_fifo_pkg.sv
// rtl/dpram_fwft_fifo_pkg.sv - sizing helpers shared by the FWFT FIFO and its RAM
package dpram_fwft_fifo_pkg;

  // Main register plus skid register behind the RAM read port.
  localparam int OUT_STAGE_ENTRIES = 2;

  function automatic int ram_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic int fifo_capacity(input int addr_width);
    return ram_depth(addr_width) + OUT_STAGE_ENTRIES;
  endfunction

  function automatic int count_width(input int addr_width);
    return $clog2(fifo_capacity(addr_width) + 1);
  endfunction

endpackage

// File: rtl/dpram_fwft_fifo_ram.sv
// rtl/dpram_fwft_fifo_ram.sv - single-clock true dual-port RAM, registered read on port B
module fifo_ram_sclk #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic                  we_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (en_b) begin
      if (we_b) mem[addr_b] <= din_b;
      else      dout_b      <= mem[addr_b];
    end
  end

endmodule

// File: rtl/dpram_fwft_fifo.sv
// rtl/dpram_fwft_fifo.sv - first-word-fall-through FIFO over a dual-port RAM with main/skid output stage
module dpram_fwft_fifo
  import dpram_fwft_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  full,
  output logic                  empty
);

  localparam int CW = ADDR_WIDTH + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(ram_depth(ADDR_WIDTH));
  localparam logic [CW-1:0] CAP_C   = CW'(fifo_capacity(ADDR_WIDTH));

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         ram_cnt;
  logic                  inflight, main_v, skid_v;
  logic [DATA_WIDTH-1:0] main_data, skid_data, ram_dout;
  logic                  wr_fire, pop, fetch;
  logic [1:0]            stage_occ;

  assign wr_ready  = (ram_cnt != DEPTH_C);
  assign wr_fire   = wr_valid & wr_ready;
  assign pop       = main_v & rd_ready;
  assign stage_occ = 2'(main_v) + 2'(skid_v) + 2'(inflight);
  // Keep at most two words committed to the output stage after this edge.
  assign fetch     = (ram_cnt != '0) && (stage_occ < (2'd2 + 2'(pop)));

  fifo_ram_sclk #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .addr_a(wr_ptr),
    .we_a  (wr_fire & ~clear),
    .din_a (wr_data),
    .addr_b(rd_ptr),
    .en_b  (fetch & ~clear),
    .we_b  (1'b0),
    .din_b ('0),
    .dout_b(ram_dout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      inflight  <= 1'b0;
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_data <= '0;
      skid_data <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      inflight  <= 1'b0;
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_data <= '0;
      skid_data <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (fetch)   rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      ram_cnt  <= ram_cnt + CW'(wr_fire) - CW'(fetch);
      inflight <= fetch;
      if (pop) begin
        if (skid_v) begin
          // Skid advances; a returning word lands behind it to keep order.
          main_data <= skid_data;
          main_v    <= 1'b1;
          skid_v    <= inflight;
          if (inflight) skid_data <= ram_dout;
        end else begin
          main_v <= inflight;
          if (inflight) main_data <= ram_dout;
        end
      end else if (inflight) begin
        if (!main_v) begin
          main_v    <= 1'b1;
          main_data <= ram_dout;
        end else begin
          skid_v    <= 1'b1;
          skid_data <= ram_dout;
        end
      end
    end
  end

  assign rd_valid = main_v;
  assign rd_data  = main_data;
  assign count    = ram_cnt + CW'(inflight) + CW'(main_v) + CW'(skid_v);
  assign full     = (count == CAP_C);
  assign empty    = (count == '0);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n && rd_valid)
      assert (!$isunknown(rd_ready)) else $error("rd_ready is X while rd_valid is high");
  end
`endif

endmodule

// File: tb/tb_dpram_fwft_fifo.sv
// tb/tb_dpram_fwft_fifo.sv - self-checking bench for dpram_fwft_fifo against a queue model
module tb_dpram_fwft_fifo;

  localparam int DW  = 8;
  localparam int AW  = 2;
  localparam int CAP = 6;

  logic          clk = 1'b0;
  logic          reset_n, clear, wr_valid, rd_ready;
  logic [DW-1:0] wr_data;
  logic          wr_ready, rd_valid, full, empty;
  logic [DW-1:0] rd_data;
  logic [AW+1:0] count;

  always #5 clk = ~clk;

  dpram_fwft_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .count(count), .full(full), .empty(empty)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model: queue of words plus the edge index each was accepted on.
  // A word may be presented from two edges after its write onward.
  logic [DW-1:0] mq[$];
  int            tq[$];
  int            cyc = 0;
  int            acc_total = 0;

  function automatic bit m_valid();
    return (mq.size() > 0) && (cyc >= tq[0] + 2);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    bit v;
    bit do_wr;
    if (!reset_n) begin
      mq.delete();
      tq.delete();
    end else begin
      v = m_valid();
      do_wr = wr_valid && (mq.size() != CAP);
      cyc++;
      if (clear) begin
        mq.delete();
        tq.delete();
      end else begin
        if (rd_ready && v) begin
          void'(mq.pop_front());
          void'(tq.pop_front());
        end
        if (do_wr) begin
          mq.push_back(wr_data);
          tq.push_back(cyc);
          acc_total++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_valid", rd_valid, m_valid());
      if (m_valid()) check("rd_data", rd_data, mq[0]);
      check("count", count, mq.size());
      check("full", full, mq.size() == CAP);
      check("empty", empty, mq.size() == 0);
      check("wr_ready", wr_ready, mq.size() != CAP);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic drain(input string nm);
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 40 && !empty; i++) tick();
    rd_ready = 1'b0;
    check(nm, empty, 1'b1);
  endtask

  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = DW'(acc_total);
      rd_ready = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  int cnt_hist[20];

  initial begin
    int target;
    int budget;
    reset_n = 1'b0; clear = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    chk_en = 1'b1;

    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_count", count, 0);
    check("rst_full", full, 1'b0);
    check("rst_empty", empty, 1'b1);

    // 1: single word latency
    wr_valid = 1'b1; wr_data = 8'hA5;
    tick();
    wr_valid = 1'b0;
    check("t1_valid_e0", rd_valid, 1'b0);
    check("t1_count_e0", count, 1);
    tick();
    check("t1_valid_e1", rd_valid, 1'b0);
    tick();
    check("t1_valid_e2", rd_valid, 1'b1);
    check("t1_data", rd_data, 8'hA5);
    check("t1_count", count, 1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("t1_empty", empty, 1'b1);

    // 2: fill to capacity, overflow attempt, ordered drain
    for (int i = 1; i <= 7; i++) begin
      wr_valid = 1'b1; wr_data = DW'(i);
      tick();
      if (i == 6) begin
        check("t2_full", full, 1'b1);
        check("t2_wr_ready", wr_ready, 1'b0);
        check("t2_count", count, 6);
      end
    end
    wr_valid = 1'b0;
    check("t2_count_after7", count, 6);
    rd_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      check("t2_drain_valid", rd_valid, 1'b1);
      check("t2_drain_data", rd_data, DW'(i));
      tick();
    end
    rd_ready = 1'b0;
    check("t2_empty", empty, 1'b1);

    // 3: streaming, one in and one out per cycle
    wr_valid = 1'b1; rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i >= 3) begin
        check("t3_valid", rd_valid, 1'b1);
        check("t3_data", rd_data, DW'(i - 3));
      end
      wr_data = DW'(i);
      tick();
      cnt_hist[i] = int'(count);
      if (i >= 3) check("t3_count_stable", count, cnt_hist[i-1]);
    end
    drain("t3_empty");

    // 4: random handshakes, 1000 words
    target = acc_total + 1000;
    budget = 0;
    while (acc_total < target && budget < 20000) begin
      random_traffic(1);
      budget++;
    end
    check("t4_budget", budget < 20000, 1'b1);
    drain("t4_empty");

    // 5: clear with a fetch in flight
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = DW'(8'h10 + i);
      tick();
    end
    wr_valid = 1'b0; rd_ready = 1'b1;
    tick();
    check("t5_count_pre", count, 4);
    clear = 1'b1; wr_valid = 1'b1; wr_data = 8'h77; rd_ready = 1'b1;
    tick();
    clear = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    check("t5_count_clr", count, 0);
    check("t5_valid_clr", rd_valid, 1'b0);
    tick();
    check("t5_valid_late", rd_valid, 1'b0);
    wr_valid = 1'b1; wr_data = 8'h3C;
    tick();
    wr_valid = 1'b0;
    tick();
    tick();
    check("t5_first_valid", rd_valid, 1'b1);
    check("t5_first_data", rd_data, 8'h3C);
    drain("t5_empty");

    // 6: asynchronous reset mid-stream
    random_traffic(30);
    wr_valid = 1'b1; rd_ready = 1'b0;
    tick();
    #3 reset_n = 1'b0;
    #1;
    check("t6_rst_valid", rd_valid, 1'b0);
    check("t6_rst_count", count, 0);
    check("t6_rst_empty", empty, 1'b1);
    check("t6_rst_wr_ready", wr_ready, 1'b1);
    check("t6_rst_data", rd_data, 8'h00);
    wr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    #2;
    random_traffic(150);
    drain("t6_empty");

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
